// File: rtl/i2c_temp_target.sv
// Read-only I2C target emulating a 16-bit temperature sensor (MSB byte first, open-drain SDA).
// Bus edges are detected SYNC_STAGES+1 clk after the pin; SDA follows one clk later; SCL is never stretched.
module i2c_temp_target #(
  parameter logic [6:0] I2C_ADDR    = 7'b1000000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCL,
  inout  wire         SDA,
  input  logic [15:0] temp_data,
  output logic        busy,
  output logic        addr_match,
  output logic        rd_done,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, TX_BYTE, RX_ACK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic        scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic        ev_start_q, ev_start_d, ev_stop_q, ev_stop_d;
  logic        ev_rise_q, ev_rise_d, ev_fall_q, ev_fall_d;
  logic        ev_bit_q, ev_bit_d;
  logic        busy_q, busy_d;
  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [15:0] shreg_q, shreg_d;
  logic        sda_oe_q, sda_oe_d;
  logic        addr_match_q, addr_match_d;
  logic        rd_done_q, rd_done_d;
  logic        bus_err_q, bus_err_d;
  logic        scl_s, sda_s, start_det, stop_det, mid_byte;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Open-drain: only ever pull low or release.
  assign SDA        = sda_oe_q ? 1'b0 : 1'bz;
  assign busy       = busy_q;
  assign addr_match = addr_match_q;
  assign rd_done    = rd_done_q;
  assign bus_err    = bus_err_q;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], SCL};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], SDA};
    scl_hist_d = scl_s;
    sda_hist_d = sda_s;

    start_det  = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    stop_det   = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
    ev_stop_d  = stop_det;
    ev_start_d = start_det & ~stop_det;
    ev_rise_d  = scl_s & ~scl_hist_q;
    ev_fall_d  = ~scl_s & scl_hist_q;
    ev_bit_d   = sda_s;

    busy_d = busy_q;
    if (stop_det) begin
      busy_d = 1'b0;
    end else if (start_det) begin
      busy_d = 1'b1;
    end

    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    shreg_d      = shreg_q;
    sda_oe_d     = sda_oe_q;
    addr_match_d = 1'b0;
    rd_done_d    = 1'b0;
    bus_err_d    = 1'b0;

    mid_byte = ((state_q == ADDR) || (state_q == TX_BYTE)) &&
               (bit_cnt_q != 4'd0) && (bit_cnt_q < 4'd8);

    if (ev_stop_q) begin
      bus_err_d = mid_byte;
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
    end else if (ev_start_q) begin
      bus_err_d = mid_byte;
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (ev_rise_q && (bit_cnt_q < 4'd8)) begin
            rx_d      = {rx_q[6:0], ev_bit_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (ev_fall_q && (bit_cnt_q == 4'd8)) begin
            bit_cnt_d = 4'd0;
            if (rx_q == {I2C_ADDR, 1'b1}) begin
              state_d      = ADDR_ACK;
              sda_oe_d     = 1'b1;
              shreg_d      = temp_data;
              addr_match_d = 1'b1;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (ev_fall_q) begin
            state_d   = TX_BYTE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = ~shreg_q[15];
            shreg_d   = {shreg_q[14:0], shreg_q[15]};
          end
        end
        TX_BYTE: begin
          // Rotating keeps the snapshot intact: after 16 bits the MSB byte comes round again.
          if (ev_rise_q && (bit_cnt_q < 4'd8)) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (ev_fall_q && (bit_cnt_q == 4'd8)) begin
            state_d   = RX_ACK;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
          end else if (ev_fall_q && (bit_cnt_q != 4'd0)) begin
            sda_oe_d = ~shreg_q[15];
            shreg_d  = {shreg_q[14:0], shreg_q[15]};
          end
        end
        RX_ACK: begin
          // bit_cnt doubles as the "master ACKed" flag while waiting for the SCL fall.
          if (ev_rise_q) begin
            if (ev_bit_q) begin
              rd_done_d = 1'b1;
              state_d   = WAIT_STOP;
            end else begin
              bit_cnt_d = 4'd1;
            end
          end else if (ev_fall_q && (bit_cnt_q == 4'd1)) begin
            state_d   = TX_BYTE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = ~shreg_q[15];
            shreg_d   = {shreg_q[14:0], shreg_q[15]};
          end
        end
        default: begin
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      scl_hist_q   <= 1'b1;
      sda_hist_q   <= 1'b1;
      ev_start_q   <= 1'b0;
      ev_stop_q    <= 1'b0;
      ev_rise_q    <= 1'b0;
      ev_fall_q    <= 1'b0;
      ev_bit_q     <= 1'b1;
      busy_q       <= 1'b0;
      state_q      <= IDLE;
      bit_cnt_q    <= 4'd0;
      rx_q         <= 8'd0;
      shreg_q      <= 16'd0;
      sda_oe_q     <= 1'b0;
      addr_match_q <= 1'b0;
      rd_done_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      scl_hist_q   <= scl_hist_d;
      sda_hist_q   <= sda_hist_d;
      ev_start_q   <= ev_start_d;
      ev_stop_q    <= ev_stop_d;
      ev_rise_q    <= ev_rise_d;
      ev_fall_q    <= ev_fall_d;
      ev_bit_q     <= ev_bit_d;
      busy_q       <= busy_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      shreg_q      <= shreg_d;
      sda_oe_q     <= sda_oe_d;
      addr_match_q <= addr_match_d;
      rd_done_q    <= rd_done_d;
      bus_err_q    <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_i2c_temp_target.sv
// Bench for i2c_temp_target: bit-banged I2C master, table of read transactions plus directed corner sequences.
module tb_i2c_temp_target;

  localparam int Q = 8;  // clk cycles per SCL quarter period

  logic        clk = 1'b0;
  logic        rst;
  logic        scl;
  logic        m_sda_oe;
  logic [15:0] temp_data;
  logic        busy, addr_match, rd_done, bus_err;
  wire         sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_sda_oe ? 1'b0 : 1'bz;

  i2c_temp_target #(.I2C_ADDR(7'b1000000), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .SCL(scl), .SDA(sda_bus), .temp_data(temp_data),
    .busy(busy), .addr_match(addr_match), .rd_done(rd_done), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_am = 0, cnt_rd = 0, cnt_be = 0, cnt_tgt_low = 0, cnt_align_bad = 0;
  logic prev_high = 1'b1;

  // Pulse counters and target-drive monitor, sampled just after the active edge.
  always @(posedge clk) begin
    #1;
    if (addr_match) cnt_am++;
    if (rd_done) cnt_rd++;
    if (bus_err) cnt_be++;
    if (!rst && !m_sda_oe && sda_bus === 1'b0) cnt_tgt_low++;
    if (addr_match && (sda_bus !== 1'b0 || !prev_high)) cnt_align_bad++;
    prev_high = (sda_bus !== 1'b0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_cycle(input logic drive_low, output logic s);
    m_sda_oe = drive_low; wq(Q);
    scl = 1'b1;           wq(Q);
    s = sda_bus;          wq(Q);
    scl = 1'b0;           wq(Q);
  endtask

  task automatic i2c_start();
    m_sda_oe = 1'b0; wq(Q);
    scl = 1'b1;      wq(Q);
    m_sda_oe = 1'b1; wq(Q);
    scl = 1'b0;      wq(Q);
  endtask

  task automatic i2c_stop();
    m_sda_oe = 1'b1; wq(Q);
    scl = 1'b1;      wq(Q);
    m_sda_oe = 1'b0; wq(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(~b[i], s);
    bit_cycle(1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack_it, output logic [7:0] b);
    logic s;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b0, s);
      b = {b[6:0], s};
    end
    bit_cycle(ack_it, s);
  endtask

  typedef struct {
    logic [7:0]  addr_byte;
    logic [15:0] temp;
    logic [15:0] temp_after;
    int          nbytes;
    logic        exp_ack;
    logic [31:0] exp_bytes;
    int          exp_am;
    int          exp_rd;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic       ack, s;
    logic [7:0] b;
    int am0, rd0, be0, tl0;

    vecs[0] = '{8'h81, 16'hABCD, 16'hABCD, 2, 1'b1, 32'hABCD_0000, 1, 1};
    vecs[1] = '{8'h83, 16'hABCD, 16'hABCD, 1, 1'b0, 32'hFF00_0000, 0, 0};
    vecs[2] = '{8'h81, 16'h1234, 16'hFFFF, 4, 1'b1, 32'h1234_1234, 1, 1};
    vecs[3] = '{8'h80, 16'h5A5A, 16'h5A5A, 1, 1'b0, 32'hFF00_0000, 0, 0};
    vecs[4] = '{8'h81, 16'h0000, 16'hFFFF, 1, 1'b1, 32'h0000_0000, 1, 1};

    rst = 1'b1; scl = 1'b1; m_sda_oe = 1'b0; temp_data = 16'h0;
    wq(4);
    rst = 1'b0;
    wq(2);
    check("reset_busy", busy, 0);
    check("reset_addr_match", addr_match, 0);
    check("reset_rd_done", rd_done, 0);
    check("reset_bus_err", bus_err, 0);
    check("reset_sda", sda_bus, 1);

    // Table-driven read transactions
    for (int v = 0; v < 5; v++) begin
      am0 = cnt_am; rd0 = cnt_rd; be0 = cnt_be; tl0 = cnt_tgt_low;
      temp_data = vecs[v].temp;
      i2c_start();
      check($sformatf("v%0d_busy_after_start", v), busy, 1);
      write_byte(vecs[v].addr_byte, ack);
      check($sformatf("v%0d_addr_ack", v), ack, vecs[v].exp_ack);
      temp_data = vecs[v].temp_after;
      for (int k = 0; k < vecs[v].nbytes; k++) begin
        read_byte(k != vecs[v].nbytes - 1, b);
        check($sformatf("v%0d_byte%0d", v, k), b, vecs[v].exp_bytes[31-8*k -: 8]);
      end
      if (!vecs[v].exp_ack) check($sformatf("v%0d_never_driven", v), cnt_tgt_low - tl0, 0);
      i2c_stop();
      check($sformatf("v%0d_busy_after_stop", v), busy, 0);
      check($sformatf("v%0d_addr_match_pulses", v), cnt_am - am0, vecs[v].exp_am);
      check($sformatf("v%0d_rd_done_pulses", v), cnt_rd - rd0, vecs[v].exp_rd);
      check($sformatf("v%0d_bus_err_pulses", v), cnt_be - be0, 0);
    end

    // Write NACK, then repeated START read, with exact busy and ACK latencies
    am0 = cnt_am; rd0 = cnt_rd; be0 = cnt_be;
    temp_data = 16'hC3A5;
    m_sda_oe = 1'b0; wq(Q);
    scl = 1'b1;      wq(Q);
    m_sda_oe = 1'b1;
    wq(2); check("busy_latency_early", busy, 0);
    wq(1); check("busy_latency_on", busy, 1);
    wq(Q - 3);
    scl = 1'b0; wq(Q);
    write_byte(8'h80, ack);
    check("write_addr_nack", ack, 0);
    i2c_start();
    for (int i = 7; i >= 1; i--) bit_cycle(~(i == 7), s);
    m_sda_oe = 1'b0; wq(Q);
    scl = 1'b1;      wq(2 * Q);
    scl = 1'b0;
    wq(3);
    check("ack_latency_early_sda", sda_bus, 1);
    check("ack_latency_early_am", addr_match, 0);
    wq(1);
    check("ack_latency_sda", sda_bus, 0);
    check("ack_latency_am", addr_match, 1);
    wq(Q - 4);
    bit_cycle(1'b0, s);
    check("rstart_addr_ack", s, 0);
    read_byte(1'b0, b);
    check("rstart_byte", b, 8'hC3);
    i2c_stop();
    check("rstart_am_pulses", cnt_am - am0, 1);
    check("rstart_rd_pulses", cnt_rd - rd0, 1);
    check("rstart_be_pulses", cnt_be - be0, 0);
    check("am_aligned_with_ack", cnt_align_bad, 0);

    // Repeated START 3 bits into the MSB byte
    am0 = cnt_am; rd0 = cnt_rd; be0 = cnt_be;
    temp_data = 16'hF00F;
    i2c_start();
    write_byte(8'h81, ack);
    check("abort_addr_ack", ack, 1);
    b = 8'h00;
    for (int i = 0; i < 3; i++) begin
      bit_cycle(1'b0, s);
      b = {b[6:0], s};
    end
    check("abort_partial_bits", b, 8'h07);
    i2c_start();
    check("abort_bus_err", cnt_be - be0, 1);
    write_byte(8'h81, ack);
    check("abort_readdr_ack", ack, 1);
    read_byte(1'b0, b);
    check("abort_new_byte", b, 8'hF0);
    i2c_stop();
    check("abort_am_pulses", cnt_am - am0, 2);
    check("abort_rd_pulses", cnt_rd - rd0, 1);

    // Asynchronous reset while the target drives a '0' data bit
    temp_data = 16'h00FF;
    i2c_start();
    write_byte(8'h81, ack);
    check("rst_addr_ack", ack, 1);
    bit_cycle(1'b0, s);
    bit_cycle(1'b0, s);
    check("rst_tgt_driving", sda_bus, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("rst_async_release", sda_bus, 1);
    wq(3);
    rst = 1'b0;
    wq(1);
    check("rst_busy", busy, 0);
    check("rst_outputs", {addr_match, rd_done, bus_err}, 3'b000);
    am0 = cnt_am; rd0 = cnt_rd; be0 = cnt_be; tl0 = cnt_tgt_low;
    for (int i = 0; i < 7; i++) bit_cycle(1'b0, s);
    check("rst_ignores_byte", cnt_tgt_low - tl0, 0);
    check("rst_no_pulses", (cnt_am - am0) + (cnt_rd - rd0) + (cnt_be - be0), 0);
    check("rst_still_idle", busy, 0);
    i2c_stop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_temp_target.md
# i2c_temp_target

Open-drain I2C target that emulates the 16-bit temperature sensor at address 0x40 on the board's SCL/SDA bus. It answers read transactions with a 16-bit value supplied by the fabric, MSB byte first, and is the bus-level counterpart of the temperature-polling I2C master. It is used as the sensor model in system simulation and as an on-chip responder when no physical sensor is fitted.

## Interface
- I2C_ADDR, 7'b1000000, 7-bit target address matched after START
- SYNC_STAGES, 2, flip-flop stages on the SCL and SDA inputs (minimum 2)
- clk  input  1  system clock; every register is clocked on its rising edge
- rst  input  1  reset, asynchronous and active-high
- SCL  input  1  bus clock, sampled only; the target never stretches the clock
- SDA  inout  1  bus data, open-drain: driven '0' or released to 'z', never driven '1'
- temp_data  input  16  value returned on reads, snapshotted at the address ACK
- busy  output  1  high from detected START to detected STOP
- addr_match  output  1  one-cycle pulse when a read to I2C_ADDR is ACKed
- rd_done  output  1  one-cycle pulse when the master NACKs the last byte
- bus_err  output  1  one-cycle pulse on a START or STOP inside a data byte

## Operation
- SCL and SDA each pass through SYNC_STAGES flops, followed by one history flop for edge detection. All decisions use the synchronized values only.
- START: SDA falls while SCL is high. It is legal in any state, including a repeated START. The block enters ADDR, clears the bit counter and releases SDA.
- STOP: SDA rises while SCL is high. The block enters IDLE from any state and releases SDA.
- Input bits are sampled on synchronized SCL rising edges. The block changes its SDA drive only on the cycle after a synchronized SCL falling edge.
- State sequence:
  - IDLE: SDA released. Waits for START.
  - ADDR: shifts in 8 bits, MSB first: the 7-bit address, then R/W.
  - Leaving ADDR (on the SCL fall after bit 8):
    - Address matches and R/W=1: go to ADDR_ACK. Drive SDA low, load temp_data into the 16-bit shift register, pulse addr_match.
    - Address mismatch, or R/W=0 (the sensor is read-only): go to WAIT_STOP. SDA stays released, which gives the master a NACK.
  - ADDR_ACK: on the next SCL fall, go to TX_BYTE and drive shift-register bit 15.
  - TX_BYTE: on each SCL fall, drive the next bit. SDA is released for a '1' and driven low for a '0'. After 8 bits, on the next SCL fall, release SDA and go to RX_ACK.
  - RX_ACK: sample SDA on the SCL rise.
    - SDA low (ACK): on the next SCL fall, return to TX_BYTE with the next byte. After the LSB byte, the next byte is the MSB byte again from the same snapshot. There is no re-load.
    - SDA high (NACK): pulse rd_done and go to WAIT_STOP.
  - WAIT_STOP: SDA released. Only START or STOP has any effect.
- A START or STOP while in ADDR or TX_BYTE with 1 to 7 bits transferred pulses bus_err, then takes its normal action.
- If START and STOP are detected in the same clk cycle, which is only possible with a glitch, STOP wins.
- Changes on temp_data after the snapshot have no effect until the next addressed read.

## Timing
- Reset values: SDA released ('z'), busy=0, addr_match=0, rd_done=0, bus_err=0, state IDLE, shift register 0.
- Reset is asynchronous: SDA is released immediately on rst assertion, including mid-byte while the block is driving low.
- Bus-edge-to-internal-detect latency is SYNC_STAGES+1 clk cycles. SDA drive changes 1 cycle later, so the SCL-fall-to-SDA-change delay is SYNC_STAGES+2 cycles.
- Requirements on clk (defaults: 45 MHz clk, CLK_PER 22 ns):
  - Output delay (SYNC_STAGES+2)·clk_period ≤ 1 µs, so data is valid before SCL rises in Fast-mode.
  - clk_period·(SYNC_STAGES+1) < tHIGH(min) and < tLOW(min).
- busy rises SYNC_STAGES+1 cycles after the physical START and falls SYNC_STAGES+1 cycles after the physical STOP.
- addr_match asserts on the same cycle SDA is first driven low for the ACK.
- The shift register loads on that same cycle.

## Test plan
- Read 0x81 (address 0x40, R), temp_data=16'hABCD, master ACKs byte 1 and NACKs byte 2 → address ACK low, master reads 0xAB then 0xCD, addr_match and rd_done pulse once each, busy drops after STOP.
- Address byte 0x83 (address 0x41) → SDA never driven low, no addr_match, state WAIT_STOP until STOP.
- Write byte 0x80 → address slot NACK (SDA high), no pulses; the following repeated START with 0x81 is ACKed and returns data normally.
- Continuous read: master ACKs 4 bytes with temp_data=16'h1234, and temp_data changes to 16'hFFFF after the ACK → bytes read are 12, 34, 12, 34.
- Repeated START after 3 bits of the MSB byte → bus_err pulse, SDA released, new address phase ACKed correctly.
- rst asserted while the target drives a '0' data bit → SDA released with no clk edge; after rst deasserts, the block is idle, all outputs are 0, and it ignores the remainder of the byte until the next START.
